// File: rtl/hw_counter_pkg.sv
// Shared constants for the hardware performance counter: bus address,
// FSM encodings, command op codes and read-select codes.
package hw_counter_pkg;

  localparam logic [31:0] HARDWARE_COUNTER_ADDR = 32'h0000_7FF0;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_SB   = 2'b01;
  localparam logic [1:0] MEM_SH   = 2'b10;
  localparam logic [1:0] MEM_SW   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] SEL_CYC_LO = 2'b00;
  localparam logic [1:0] SEL_CYC_HI = 2'b01;
  localparam logic [1:0] SEL_INS_LO = 2'b10;
  localparam logic [1:0] SEL_INS_HI = 2'b11;

  function automatic logic [31:0] hc_select(input logic [1:0]  sel,
                                            input logic [63:0] cyc,
                                            input logic [63:0] ins);
    logic [31:0] word;
    word = '0;
    case (sel)
      SEL_CYC_LO: word = cyc[31:0];
      SEL_CYC_HI: word = cyc[63:32];
      SEL_INS_LO: word = ins[31:0];
      SEL_INS_HI: word = ins[63:32];
      default:    word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/hc_counter_core.sv
// Counter FSM (IDLE/RUN/HALT) with the cycle and retired-instruction counters.
// Exposes next-state counter values so the read register can sample post-edge data.
module hc_counter_core
  import hw_counter_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic             retire1,
  input  logic             retire2,
  output logic [CNT_W-1:0] cycle_nxt,
  output logic [CNT_W-1:0] instret_nxt
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             count;

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    count     = 1'b0;
    // start/stop/clear edges never count; only a nop or an empty cycle does
    if (cmd_valid) begin
      case (cmd_op)
        OP_START: state_d = ST_RUN;
        OP_STOP:  if (state_q == ST_RUN) state_d = ST_HALT;
        OP_CLEAR: begin
          state_d   = ST_IDLE;
          cycle_d   = '0;
          instret_d = '0;
        end
        default:  count = (state_q == ST_RUN);
      endcase
    end else begin
      count = (state_q == ST_RUN);
    end
    if (count) begin
      cycle_d   = cycle_q + CNT_W'(1);
      instret_d = instret_q + CNT_W'(retire1) + CNT_W'(retire2);
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q   <= ST_IDLE;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_nxt   = cycle_d;
  assign instret_nxt = instret_d;

endmodule

// File: rtl/hw_counter.sv
// Memory-mapped cycle/instret counter snooping both MEM-stage store lanes;
// the selected 32-bit word is registered for data_ram to return on LW.
module hw_counter
  import hw_counter_pkg::*;
#(
  parameter logic [31:0] HC_ADDR = HARDWARE_COUNTER_ADDR,
  parameter int unsigned CNT_W   = 64
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [31:0] resultM1,
  input  logic [31:0] resultM2,
  input  logic [31:0] Source1,
  input  logic [31:0] Source2,
  input  logic [1:0]  mem_store1,
  input  logic [1:0]  mem_store2,
  input  logic        retire1,
  input  logic        retire2,
  output logic [31:0] hc_OUT_data
);

  logic             l1_hit, l2_hit, cmd_valid;
  logic [3:0]       cmd_word;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cycle_nxt, instret_nxt;
  logic [63:0]      cyc_w, ins_w;
  logic [31:0]      word_d;
  logic             unused_src;

  assign l1_hit    = (mem_store1 == MEM_SW) && (resultM1 == HC_ADDR);
  assign l2_hit    = (mem_store2 == MEM_SW) && (resultM2 == HC_ADDR);
  assign cmd_valid = l1_hit || l2_hit;
  // lane 2 holds the younger instruction, so its command overrides lane 1's
  assign cmd_word  = l2_hit ? Source2[3:0] : Source1[3:0];
  assign unused_src = ^{Source1[31:4], Source2[31:4]};

  hc_counter_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .CLK        (CLK),
    .NRST       (NRST),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_word[1:0]),
    .retire1    (retire1),
    .retire2    (retire2),
    .cycle_nxt  (cycle_nxt),
    .instret_nxt(instret_nxt)
  );

  assign sel_d  = cmd_valid ? cmd_word[3:2] : sel_q;
  assign cyc_w  = 64'(cycle_nxt);
  assign ins_w  = 64'(instret_nxt);
  assign word_d = hc_select(sel_d, cyc_w, ins_w);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      sel_q       <= SEL_CYC_LO;
      hc_OUT_data <= '0;
    end else begin
      sel_q       <= sel_d;
      hc_OUT_data <= word_d;
    end
  end

endmodule

// File: tb/tb_hw_counter.sv
// Scoreboard bench for hw_counter: driver updates a reference model and queues
// the expected read word; a monitor pops and compares after every rising edge.
module tb_hw_counter;

  localparam logic [31:0] HC = 32'h0000_7FF0;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic [31:0] resultM1 = '0, resultM2 = '0, Source1 = '0, Source2 = '0;
  logic [1:0]  mem_store1 = '0, mem_store2 = '0;
  logic        retire1 = 1'b0, retire2 = 1'b0;
  logic [31:0] hc_OUT_data;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] exp_q[$];

  int          m_state = M_IDLE;
  logic [63:0] m_cyc = '0;
  logic [63:0] m_ins = '0;
  logic [1:0]  m_sel = '0;

  hw_counter #(
    .HC_ADDR(HC),
    .CNT_W  (64)
  ) dut (
    .CLK        (CLK),
    .NRST       (NRST),
    .resultM1   (resultM1),
    .resultM2   (resultM2),
    .Source1    (Source1),
    .Source2    (Source2),
    .mem_store1 (mem_store1),
    .mem_store2 (mem_store2),
    .retire1    (retire1),
    .retire2    (retire2),
    .hc_OUT_data(hc_OUT_data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, got, want);
    end
  endtask

  function automatic logic [31:0] model_word();
    case (m_sel)
      2'd0:    return m_cyc[31:0];
      2'd1:    return m_cyc[63:32];
      2'd2:    return m_ins[31:0];
      default: return m_ins[63:32];
    endcase
  endfunction

  task automatic model_edge(input logic [31:0] a1, d1, input logic [1:0] s1, input logic r1,
                            input logic [31:0] a2, d2, input logic [1:0] s2, input logic r2);
    bit          hit1, hit2, tick;
    logic [31:0] d;
    hit1 = (s1 == 2'b11) && (a1 == HC);
    hit2 = (s2 == 2'b11) && (a2 == HC);
    d    = hit2 ? d2 : d1;
    tick = (m_state == M_RUN);
    if (hit1 || hit2) begin
      m_sel = d[3:2];
      if (d[1:0] == 2'b01) begin
        m_state = M_RUN;
        tick = 0;
      end else if (d[1:0] == 2'b10) begin
        if (m_state == M_RUN) m_state = M_HALT;
        tick = 0;
      end else if (d[1:0] == 2'b11) begin
        m_state = M_IDLE;
        m_cyc = '0;
        m_ins = '0;
        tick = 0;
      end
    end
    if (tick) begin
      m_cyc = m_cyc + 64'd1;
      m_ins = m_ins + 64'(r1) + 64'(r2);
    end
  endtask

  // called just after a falling edge; returns just after the next falling edge
  task automatic drive(input logic [31:0] a1, d1, input logic [1:0] s1, input logic r1,
                       input logic [31:0] a2, d2, input logic [1:0] s2, input logic r2);
    resultM1 = a1; Source1 = d1; mem_store1 = s1; retire1 = r1;
    resultM2 = a2; Source2 = d2; mem_store2 = s2; retire2 = r2;
    model_edge(a1, d1, s1, r1, a2, d2, s2, r2);
    exp_q.push_back(model_word());
    @(negedge CLK);
  endtask

  task automatic sw1(input logic [31:0] data);
    drive(HC, data, 2'b11, 1'b0, '0, '0, 2'b00, 1'b0);
  endtask

  task automatic idle(input int n, input logic r1, input logic r2);
    for (int i = 0; i < n; i++) drive('0, '0, 2'b00, r1, '0, '0, 2'b00, r2);
  endtask

  task automatic mid_reset();
    resultM1 = '0; Source1 = '0; mem_store1 = '0; retire1 = 1'b1;
    resultM2 = '0; Source2 = '0; mem_store2 = '0; retire2 = 1'b1;
    #2 NRST = 1'b0;
    #1 check("async_reset", hc_OUT_data, 32'h0);
    m_state = M_IDLE; m_cyc = '0; m_ins = '0; m_sel = '0;
    exp_q.push_back(32'h0);
    @(negedge CLK);
    NRST = 1'b1;
  endtask

  task automatic rand_lane(output logic [31:0] a, output logic [31:0] d, output logic [1:0] s);
    int unsigned k;
    k = $urandom_range(0, 9);
    d = $urandom;
    if (k <= 2)      begin a = HC;        s = 2'b11; end
    else if (k == 3) begin a = HC;        s = 2'($urandom_range(1, 2)); end
    else if (k == 4) begin a = HC + 32'd4; s = 2'b11; end
    else             begin a = $urandom;  s = 2'($urandom_range(0, 3)); end
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hc_OUT_data", hc_OUT_data, e);
      end
    end
  end

  initial begin : driver
    logic [31:0] a1, d1, a2, d2;
    logic [1:0]  s1, s2;
    #1 check("reset_out", hc_OUT_data, 32'h0);
    @(negedge CLK);
    NRST = 1'b1;

    // start, ten dual-retire cycles, stop, then read instret lo and cycle hi
    sw1(32'h1);
    idle(10, 1'b1, 1'b1);
    sw1(32'h2);
    sw1(32'h8);
    sw1(32'h4);

    // 64-bit cycle wrap from all-ones
    sw1(32'h1);
    idle(1, 1'b0, 1'b0);
    force dut.u_core.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.u_core.cycle_q;
    m_cyc = 64'hFFFF_FFFF_FFFF_FFFF;
    idle(1, 1'b0, 1'b0);
    sw1(32'h4);

    // same-cycle commands: lane 2 clear/sel 11 beats lane 1 stop
    drive(HC, 32'h2, 2'b11, 1'b1, HC, 32'hF, 2'b11, 1'b1);
    sw1(32'h8);

    // SB to the counter and SW to the neighbouring word are not commands
    drive(HC, 32'h1, 2'b01, 1'b1, HC + 32'd4, 32'h1, 2'b11, 1'b1);
    drive(HC + 32'd4, 32'h1, 2'b11, 1'b1, HC, 32'h1, 2'b10, 1'b1);
    idle(2, 1'b1, 1'b1);
    sw1(32'h0);

    // reset in the middle of a run, then no counting until a fresh start
    sw1(32'h1);
    idle(5, 1'b1, 1'b0);
    mid_reset();
    idle(3, 1'b1, 1'b1);
    sw1(32'h1);
    idle(3, 1'b1, 1'b1);
    sw1(32'h8);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        mid_reset();
      end else begin
        rand_lane(a1, d1, s1);
        rand_lane(a2, d2, s2);
        drive(a1, d1, s1, 1'($urandom), a2, d2, s2, 1'($urandom));
      end
    end

    @(posedge CLK);
    #2 check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hw_counter.md
HW_COUNTER -- requirements
Module: hw_counter

Interface
REQ-001 Parameter HC_ADDR, default `HARDWARE_COUNTER_ADDR (define.vh), byte address of the counter control/read word.
REQ-002 Parameter CNT_W, default 64, width of each counter.
REQ-003 One clock; reset is asynchronous and active-low; ports named CLK and NRST.
REQ-004 CLK  in  1  clock, all state updates on rising edge.
REQ-005 NRST  in  1  async active-low reset.
REQ-006 resultM1, resultM2  in  32  MEM-stage effective addresses, lanes 1/2.
REQ-007 Source1, Source2  in  32  MEM-stage store data, lanes 1/2.
REQ-008 mem_store1, mem_store2  in  2  store type per lane: 01 SB, 10 SH, 11 SW, 00 none.
REQ-009 retire1, retire2  in  1  lane retired an instruction this cycle.
REQ-010 hc_OUT_data  out  32  selected counter word, consumed by data_ram on LW to HC_ADDR.

Function
REQ-011 Lane n issues a command when mem_store_n == 11 and resultM_n == HC_ADDR; SB/SH to HC_ADDR are ignored.
REQ-012 If both lanes issue a command in the same cycle, lane 2 (younger) wins; lane 1's command is discarded entirely.
REQ-013 Command word fields: Source[1:0] op (00 nop, 01 start, 10 stop, 11 clear); Source[3:2] read select; Source[31:4] ignored.
REQ-014 Every accepted command loads read select from Source[3:2], whatever the op.
REQ-015 Read select: 00 cycle[31:0], 01 cycle[63:32], 10 instret[31:0], 11 instret[63:32].
REQ-016 FSM states IDLE, RUN, HALT.
REQ-017 Transitions: IDLE/HALT --start--> RUN; RUN --stop--> HALT; any state --clear--> IDLE; all other op/state pairs keep the state.
REQ-018 In RUN with no accepted command: cycle += 1 and instret += retire1 + retire2 (0, 1 or 2) on each edge.
REQ-019 The edge that accepts start, stop or clear does not increment either counter.
REQ-020 A nop command in RUN increments normally.
REQ-021 Clear zeroes both counters on the accepting edge.
REQ-022 Counters wrap modulo 2^CNT_W silently.
REQ-023 Counters hold their values in IDLE and HALT.
REQ-024 hc_OUT_data is a register loaded every edge with the word chosen by the post-edge read select from the post-edge counter values (one-cycle latency after any change).

Reset
REQ-025 NRST low: state IDLE, cycle 0, instret 0, read select 00, hc_OUT_data 0, all immediately (asynchronously).
REQ-026 Reset asserted mid-RUN discards counts; after release the block counts only after a new start.

Structure
REQ-027 FSM state encodings, op codes and read-select codes go in the shared define.vh alongside HARDWARE_COUNTER_ADDR.
REQ-028 Natural sub-module: hc_counter_core (FSM plus two counters); command decode and output register stay in hw_counter.
REQ-029 The block is instantiated beside data_ram and shares its MEM-stage address/store/data nets.

Verification
REQ-030 Reset, then SW lane1 addr HC_ADDR data 0x1; 10 cycles of retire1=retire2=1; SW data 0x2 -> cycle 10, instret 20, state HALT.
REQ-031 From REQ-030 state, SW data 0x8 (nop, sel 10) -> hc_OUT_data 20 one cycle later; then data 0x4 (nop, sel 01) -> 0.
REQ-032 Preload cycle to 0xFFFFFFFF_FFFFFFFF via force, RUN one cycle -> cycle 0; hc_OUT_data sel 00 and sel 01 both read 0.
REQ-033 Same-cycle SW to HC_ADDR: lane1 data 0x2 (stop), lane2 data 0xF (clear, sel 11) -> state IDLE, counters 0, sel 11.
REQ-034 SB lane1 to HC_ADDR data 0x1, and SW to HC_ADDR+4 data 0x1 -> state stays IDLE, counters unchanged.
REQ-035 NRST pulsed low mid-RUN (cycle 5) between clock edges -> all outputs 0 immediately; no counting after release until start.
